// File: rtl/dual_inst_queue.sv
// dual_inst_queue
//   Circular instruction queue sitting between the 64-bit fetch stage and the
//   two decoders. Each cycle it accepts a fetch packet of up to two 32-bit
//   instructions, compacts the packet by its valid mask, and presents the two
//   oldest instructions in program order to decoder 0 and decoder 1. The
//   decoders report how many they consumed (0..2). Flush discards everything.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   flush        in   discard all queued entries
//   fetch_valid  in   fetch packet present
//   fetch_pc     in   PC of slot 0 (slot 1 is fetch_pc + 4)
//   fetch_inst   in   [31:0] slot 0 instruction, [63:32] slot 1 instruction
//   fetch_mask   in   bit0 slot 0 valid, bit1 slot 1 valid
//   fetch_ready  out  room for a full two-instruction packet
//   deq0_*       out  oldest entry (valid / inst / pc)
//   deq1_*       out  second-oldest entry (valid / inst / pc)
//   deq_count    in   entries consumed this cycle (3 is treated as 2)
//   count        out  current occupancy
module dual_inst_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               fetch_valid,
    input  logic [31:0]        fetch_pc,
    input  logic [63:0]        fetch_inst,
    input  logic [1:0]         fetch_mask,
    output logic               fetch_ready,
    output logic               deq0_valid,
    output logic [31:0]        deq0_inst,
    output logic [31:0]        deq0_pc,
    output logic               deq1_valid,
    output logic [31:0]        deq1_inst,
    output logic [31:0]        deq1_pc,
    input  logic [1:0]         deq_count,
    output logic [PTR_W:0]     count
);

    localparam int          CNT_W    = PTR_W + 1;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    // Highest occupancy that still leaves room for two entries.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

    // Storage is deliberately not reset; validity comes from count_q only.
    logic [31:0] mem_inst [DEPTH];
    logic [31:0] mem_pc   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             enq_fire;
    logic [1:0]       enq_n;
    logic [1:0]       deq_req;
    logic [1:0]       deq_n;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [31:0]      wr0_inst;
    logic [31:0]      wr0_pc;

    assign fetch_ready = (count_q <= READY_MAX);
    assign enq_fire    = fetch_valid && fetch_ready && !flush;
    assign head_p1     = head_q + PTR_W'(1);
    assign tail_p1     = tail_q + PTR_W'(1);

    // A lone slot-1 instruction is compacted down to the tail entry.
    assign wr0_inst = (fetch_mask == 2'b10) ? fetch_inst[63:32] : fetch_inst[31:0];
    assign wr0_pc   = (fetch_mask == 2'b10) ? (fetch_pc + 32'd4) : fetch_pc;

    always_comb begin
        enq_n = 2'd0;
        if (enq_fire) begin
            case (fetch_mask)
                2'b11:        enq_n = 2'd2;
                2'b01, 2'b10: enq_n = 2'd1;
                default:      enq_n = 2'd0;
            endcase
        end
    end

    // Over-consume is clamped to what is actually held.
    always_comb begin
        deq_req = (deq_count == 2'd3) ? 2'd2 : deq_count;
        deq_n   = deq_req;
        if (CNT_W'(deq_req) > count_q) begin
            deq_n = count_q[1:0];
        end
    end

    always_comb begin
        head_d  = head_q + PTR_W'(deq_n);
        tail_d  = tail_q + PTR_W'(enq_n);
        count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire && !reset && (fetch_mask != 2'b00)) begin
            mem_inst[tail_q] <= wr0_inst;
            mem_pc[tail_q]   <= wr0_pc;
            if (fetch_mask == 2'b11) begin
                mem_inst[tail_p1] <= fetch_inst[63:32];
                mem_pc[tail_p1]   <= fetch_pc + 32'd4;
            end
        end
    end

    assign deq0_valid = (count_q != '0);
    assign deq1_valid = (count_q >= CNT_W'(2));
    assign deq0_inst  = deq0_valid ? mem_inst[head_q]  : NOP_INST;
    assign deq0_pc    = deq0_valid ? mem_pc[head_q]    : 32'd0;
    assign deq1_inst  = deq1_valid ? mem_inst[head_p1] : NOP_INST;
    assign deq1_pc    = deq1_valid ? mem_pc[head_p1]   : 32'd0;
    assign count      = count_q;

endmodule

// File: tb/tb_dual_inst_queue.sv
// tb_dual_inst_queue
//   Directed and randomized stimulus for dual_inst_queue, checked every cycle
//   against a queue-based reference model of the instruction stream.
module tb_dual_inst_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, flush, fetch_valid;
    logic [31:0] fetch_pc;
    logic [63:0] fetch_inst;
    logic [1:0]  fetch_mask, deq_count;
    logic        fetch_ready, deq0_valid, deq1_valid;
    logic [31:0] deq0_inst, deq0_pc, deq1_inst, deq1_pc;
    logic [3:0]  count;

    int vectors = 0;
    int errors  = 0;

    // Reference contents, oldest first: {inst, pc}.
    logic [63:0] mq[$];

    dual_inst_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_inst(fetch_inst), .fetch_mask(fetch_mask),
        .fetch_ready(fetch_ready),
        .deq0_valid(deq0_valid), .deq0_inst(deq0_inst), .deq0_pc(deq0_pc),
        .deq1_valid(deq1_valid), .deq1_inst(deq1_inst), .deq1_pc(deq1_pc),
        .deq_count(deq_count), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int          sz;
        logic [63:0] e0, e1;
        sz = mq.size();
        e0 = (sz >= 1) ? mq[0] : {NOP, 32'd0};
        e1 = (sz >= 2) ? mq[1] : {NOP, 32'd0};
        chk("count",       64'(count),       64'(sz));
        chk("fetch_ready", 64'(fetch_ready), 64'((8 - sz) >= 2));
        chk("deq0_valid",  64'(deq0_valid),  64'(sz >= 1));
        chk("deq1_valid",  64'(deq1_valid),  64'(sz >= 2));
        chk("deq0",        {deq0_inst, deq0_pc}, e0);
        chk("deq1",        {deq1_inst, deq1_pc}, e1);
    endtask

    task automatic model_step(input logic r, input logic f, input logic v,
                              input logic [31:0] pc, input logic [63:0] inst,
                              input logic [1:0] m, input logic [1:0] dc);
        int sz, req, dn;
        bit rdy;
        if (r || f) begin
            mq.delete();
        end else begin
            sz  = mq.size();
            req = (dc == 2'd3) ? 2 : int'(dc);
            dn  = (req < sz) ? req : sz;
            rdy = (8 - sz) >= 2;
            for (int i = 0; i < dn; i++) void'(mq.pop_front());
            if (v && rdy) begin
                if (m[0]) mq.push_back({inst[31:0], pc});
                if (m[1]) mq.push_back({inst[63:32], pc + 32'd4});
            end
        end
    endtask

    // Apply one cycle of inputs: check the current state at negedge, then
    // advance the model on the rising edge. Returns at posedge + 1.
    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [31:0] pc, input logic [63:0] inst,
                         input logic [1:0] m, input logic [1:0] dc);
        reset = r; flush = f; fetch_valid = v; fetch_pc = pc;
        fetch_inst = inst; fetch_mask = m; deq_count = dc;
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_step(r, f, v, pc, inst, m, dc);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 2'b00, 2'd0);
    endtask

    initial begin
        logic [31:0] pc;
        reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
        fetch_inst = '0; fetch_mask = 2'b00; deq_count = 2'd0;
        @(posedge clk); @(posedge clk); #1;
        mq.delete();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(fetch_ready), 64'd1);
        chk("rst_valids", 64'({deq0_valid, deq1_valid}), 64'd0);
        chk("rst_deq0", {deq0_inst, deq0_pc}, {NOP, 32'd0});
        chk("rst_deq1", {deq1_inst, deq1_pc}, {NOP, 32'd0});

        // Full packet becomes visible next cycle in program order.
        drive(1'b0, 1'b0, 1'b1, 32'h100, {32'hBBBB_0002, 32'hAAAA_0001}, 2'b11, 2'd0);
        chk("t1_deq0", {deq0_inst, deq0_pc}, {32'hAAAA_0001, 32'h100});
        chk("t1_deq1", {deq1_inst, deq1_pc}, {32'hBBBB_0002, 32'h104});
        chk("t1_count", 64'(count), 64'd2);

        // Lone slot-1 instruction compacts to the front with pc + 4.
        drive(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 2'b00, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h200, {32'hBBBB_0004, 32'hAAAA_0003}, 2'b10, 2'd0);
        chk("t2_deq0", {deq0_inst, deq0_pc}, {32'hBBBB_0004, 32'h204});
        chk("t2_deq1v", 64'(deq1_valid), 64'd0);
        chk("t2_count", 64'(count), 64'd1);

        // Fill to full; a fifth packet is dropped; drain back to ready.
        drive(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 2'b00, 2'd0);
        for (int i = 0; i < 5; i++)
            drive(1'b0, 1'b0, 1'b1, 32'h1000 + 32'(i * 8),
                  {$urandom, $urandom}, 2'b11, 2'd0);
        chk("t3_full_count", 64'(count), 64'd8);
        chk("t3_full_ready", 64'(fetch_ready), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 2'b00, 2'd1);
        chk("t3_c7", 64'({count, fetch_ready}), 64'({4'd7, 1'b0}));
        drive(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 2'b00, 2'd1);
        chk("t3_c6", 64'({count, fetch_ready}), 64'({4'd6, 1'b1}));

        // Streaming push/pop across several pointer wraps.
        drive(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 2'b00, 2'd0);
        pc = 32'h4000;
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, 1'b0, 1'b1, pc, {$urandom, $urandom}, 2'b11, 2'd2);
            chk("t4_count", 64'(count), 64'd2);
            pc += 32'd8;
        end

        // Flush beats same-cycle enqueue and dequeue.
        drive(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 2'b00, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h500, {$urandom, $urandom}, 2'b11, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h508, {$urandom, $urandom}, 2'b11, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h510, {$urandom, $urandom}, 2'b01, 2'd0);
        chk("t5_pre", 64'(count), 64'd5);
        drive(1'b0, 1'b1, 1'b1, 32'h518, {$urandom, $urandom}, 2'b11, 2'd2);
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_valids", 64'({deq0_valid, deq1_valid}), 64'd0);
        chk("t5_ready", 64'(fetch_ready), 64'd1);

        // Over-consume clamps at zero; reset mid-push leaves nothing valid.
        drive(1'b0, 1'b0, 1'b1, 32'h600, {$urandom, $urandom}, 2'b01, 2'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 2'b00, 2'd2);
        chk("t6_clamp", 64'(count), 64'd0);
        idle();
        chk("t6_empty", 64'(count), 64'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h700, {$urandom, $urandom}, 2'b11, 2'd0);
        drive(1'b1, 1'b0, 1'b1, 32'h708, {$urandom, $urandom}, 2'b11, 2'd0);
        chk("t6_rst", 64'({count, deq0_valid, deq1_valid}), 64'd0);

        // Randomized traffic against the model.
        pc = 32'h8000;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 3) != 0), pc, {$urandom, $urandom},
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            pc += 32'd8;
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
